// File: rtl/instr_encode_loader.sv
// instr_encode_loader: encodes instruction descriptors into RV32 words and streams them into instruction memory
module instr_encode_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [19:0]       imm,
  input  logic [9:0]        mem_addr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;
  state_t state;
  logic [31:0] word;
  logic last;
  assign last = count == (ADDR_W+1)'(DEPTH - 1);
  assign in_ready = state == IDLE && !clear && !rst;
  assign imem_we = state == WRITE && !clear && !rst;
  assign full = state == FULL;
  always_comb begin
    word = 32'h0000_0013;
    case (op_sel)
      3'd0: word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd1: word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd2: word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      3'd3: word = {7'b0000000, mem_addr, 3'b000, rd, 7'b0000011};
      3'd4: word = {7'b0000000, mem_addr, 3'b000, rd, 7'b0100011};
      3'd5: word = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], 7'b1100011};
      3'd6: word = {imm[19], imm[9:0], imm[10], imm[18:11], rd, 7'b1101111};
      default: word = 32'h0000_0013;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      imem_addr <= '0;
      imem_wdata <= '0;
      count <= '0;
      err <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      imem_addr <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= WRITE;
          imem_wdata <= word;
          err <= err | (op_sel == 3'd7);
        end
        WRITE: begin
          count <= count + 1'b1;
          imem_addr <= imem_addr + ADDR_W'(!last);
          state <= last ? FULL : IDLE;
        end
        default: state <= FULL;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: directed vector and corner-sequence checks for instr_encode_loader
module tb_instr_encode_loader;
  logic clk = 1'b0;
  logic rst, clear, in_valid, v2;
  logic [2:0] op_sel;
  logic [4:0] rd, rs1, rs2;
  logic [19:0] imm;
  logic [9:0] mem_addr;
  logic in_ready, imem_we, full, err;
  logic rdy2, we2, full2, err2;
  logic [7:0] imem_addr;
  logic [1:0] addr2;
  logic [31:0] imem_wdata, wdata2;
  logic [8:0] count;
  logic [2:0] count2;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  instr_encode_loader dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_addr(mem_addr),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );
  instr_encode_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(v2), .in_ready(rdy2),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_addr(mem_addr),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .count(count2), .full(full2), .err(err2)
  );
  typedef struct {
    logic [2:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [19:0] imm;
    logic [9:0] ma;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[16];
  vec_t add_v;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input vec_t v);
    op_sel = v.op;
    rd = v.rd;
    rs1 = v.rs1;
    rs2 = v.rs2;
    imm = v.imm;
    mem_addr = v.ma;
  endtask
  task automatic send(input vec_t v, input int addr, input string tag);
    drive(v);
    in_valid = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    chk({tag, "_we"}, 32'(imem_we), 32'd1);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(addr));
    chk({tag, "_word"}, imem_wdata, v.word);
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    tick;
    chk({tag, "_we_off"}, 32'(imem_we), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'(addr + 1));
  endtask
  initial begin
    vecs[0]  = '{3'd0, 5'd3, 5'd1, 5'd2, 20'h00000, 10'h000, 32'h002081B3};
    vecs[1]  = '{3'd1, 5'd3, 5'd1, 5'd2, 20'hFFFFF, 10'h3FF, 32'h402081B3};
    vecs[2]  = '{3'd2, 5'd5, 5'd0, 5'd31, 20'h0000A, 10'h155, 32'h00A00293};
    vecs[3]  = '{3'd3, 5'd4, 5'd7, 5'd9, 20'hFFFFF, 10'h3FF, 32'h01FF8203};
    vecs[4]  = '{3'd6, 5'd1, 5'd5, 5'd6, 20'h00000, 10'h3FF, 32'h000000EF};
    vecs[5]  = '{3'd4, 5'd6, 5'd31, 5'd31, 20'hFFFFF, 10'h155, 32'h00AA8323};
    vecs[6]  = '{3'd5, 5'd31, 5'd1, 5'd2, 20'h00004, 10'h3FF, 32'h00208463};
    vecs[7]  = '{3'd5, 5'd9, 5'd0, 5'd0, 20'h00FFF, 10'h000, 32'hFE000FE3};
    vecs[8]  = '{3'd5, 5'd0, 5'd0, 5'd0, 20'h00400, 10'h000, 32'h000000E3};
    vecs[9]  = '{3'd5, 5'd0, 5'd0, 5'd0, 20'h00800, 10'h000, 32'h80000063};
    vecs[10] = '{3'd5, 5'd0, 5'd0, 5'd0, 20'h00010, 10'h000, 32'h02000063};
    vecs[11] = '{3'd6, 5'd0, 5'd3, 5'd3, 20'hFFFFF, 10'h3FF, 32'hFFFFF06F};
    vecs[12] = '{3'd6, 5'd2, 5'd0, 5'd0, 20'h00001, 10'h000, 32'h0020016F};
    vecs[13] = '{3'd6, 5'd0, 5'd0, 5'd0, 20'h00400, 10'h000, 32'h0010006F};
    vecs[14] = '{3'd6, 5'd0, 5'd0, 5'd0, 20'h00800, 10'h000, 32'h0000106F};
    vecs[15] = '{3'd2, 5'd0, 5'd0, 5'd0, 20'hFFFFF, 10'h000, 32'hFFF00013};
    add_v = vecs[0];
    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    v2 = 1'b0;
    drive(add_v);
    tick;
    tick;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_addr", 32'(imem_addr), 32'd0);
    chk("post_rst_wdata", imem_wdata, 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_full", 32'(full), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    for (int i = 0; i < 16; i++) send(vecs[i], i, $sformatf("vec%0d", i));
    chk("err_clean", 32'(err), 32'd0);
    send('{3'd7, 5'd9, 5'd8, 5'd7, 20'hABCDE, 10'h2AA, 32'h00000013}, 16, "unsup");
    chk("err_set", 32'(err), 32'd1);
    send(add_v, 17, "after_unsup");
    chk("err_sticky", 32'(err), 32'd1);
    drive(add_v);
    clear = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("clear_ready", 32'(in_ready), 32'd0);
    tick;
    clear = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clear_no_accept", 32'(imem_we), 32'd0);
    chk("clear_err", 32'(err), 32'd0);
    chk("clear_count", 32'(count), 32'd0);
    chk("clear_addr", 32'(imem_addr), 32'd0);
    send(vecs[2], 0, "post_clear");
    drive(vecs[1]);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("clear_write_we", 32'(imem_we), 32'd0);
    tick;
    clear = 1'b0;
    #1;
    chk("clear_write_count", 32'(count), 32'd0);
    send(add_v, 0, "after_clear_write");
    drive(vecs[3]);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_write_we", 32'(imem_we), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("rst_write_count", 32'(count), 32'd0);
    send(vecs[4], 0, "after_rst_write");
    clear = 1'b1;
    tick;
    clear = 1'b0;
    drive(add_v);
    v2 = 1'b1;
    begin
      int n = 0;
      for (int c = 0; c < 14; c++) begin
        tick;
        if (we2) begin
          chk("full_addr", 32'(addr2), 32'(n));
          chk("full_word", wdata2, 32'h002081B3);
          n++;
        end
      end
      chk("full_writes", 32'(n), 32'd4);
    end
    chk("full_flag", 32'(full2), 32'd1);
    chk("full_count", 32'(count2), 32'd4);
    chk("full_ready", 32'(rdy2), 32'd0);
    chk("full_no_wrap", 32'(addr2), 32'd3);
    chk("full_we", 32'(we2), 32'd0);
    v2 = 1'b0;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    #1;
    chk("full_cleared", 32'(full2), 32'd0);
    chk("full_cleared_ready", 32'(rdy2), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_encode_loader.md
INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width; DEPTH = 2^ADDR_W words.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port clear  input  1  synchronous restart: zero write pointer, count, full and err.
REQ-005 SHALL have port in_valid  input  1  descriptor valid.
REQ-006 SHALL have port in_ready  output  1  descriptor accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 SHALL have port op_sel  input  3  0 ADD, 1 SUB, 2 ADDI, 3 LOAD, 4 STORE, 5 BEQ, 6 JAL, 7 unsupported.
REQ-008 SHALL have ports rd, rs1, rs2  input  5 each  register fields.
REQ-009 SHALL have port imm  input  20  immediate/offset field.
REQ-010 SHALL have port mem_addr  input  10  data address for LOAD/STORE.
REQ-011 SHALL have ports imem_we  output  1, imem_addr  output  ADDR_W, imem_wdata  output  32  instruction-memory write port.
REQ-012 SHALL have ports count  output  ADDR_W+1  words written; full  output  1; err  output  1  sticky unsupported-op flag.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, FULL.
REQ-014 in_ready SHALL be 1 only in IDLE with clear low.
REQ-015 Acceptance in IDLE SHALL register the encoded word and move to WRITE; imem_we SHALL be 1 for exactly the following cycle with imem_addr = current pointer.
REQ-016 WRITE SHALL increment pointer and count by 1; next state FULL when count reaches DEPTH, else IDLE; throughput is one descriptor per two cycles.
REQ-017 FULL SHALL hold in_ready=0, full=1, imem_we=0 until rst or clear.
REQ-018 ADD/SUB SHALL encode funct7 (0000000 / 0100000) at [31:25], rs2 at [24:20], rs1 at [19:15], funct3 000, rd at [11:7], opcode 0110011.
REQ-019 ADDI SHALL encode imm[11:0] at [31:20], rs1, funct3 000, rd, opcode 0010011.
REQ-020 LOAD SHALL encode zeros at [31:25], mem_addr at [24:15], funct3 000, rd at [11:7], opcode 0000011; STORE identical with rd field carrying the source register and opcode 0100011.
REQ-021 BEQ SHALL treat imm[11:0] as offset[12:1]: [31]=imm[11], [30:25]=imm[9:4], rs2, rs1, funct3 000, [11:8]=imm[3:0], [7]=imm[10], opcode 1100011.
REQ-022 JAL SHALL treat imm[19:0] as offset[20:1]: [31]=imm[19], [30:21]=imm[9:0], [20]=imm[10], [19:12]=imm[18:11], rd, opcode 1101111.
REQ-023 op_sel 7 SHALL be written as NOP 0x00000013 (normal write) and set err, which stays set until rst or clear.
REQ-024 Unused input fields for an op SHALL NOT affect the encoded word.
REQ-025 clear asserted in WRITE SHALL suppress that write (imem_we=0), return to IDLE with zeroed state; clear together with in_valid SHALL NOT accept.
REQ-026 rst SHALL take priority over clear; clear over in_valid.
REQ-027 Pointer SHALL NOT wrap; the DEPTH-th write lands at address DEPTH-1, then FULL.

Reset
REQ-028 On rst: state IDLE, in_ready=0 during reset cycle then 1, imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, err=0.
REQ-029 Reset mid-WRITE SHALL drop the pending write (no imem_we pulse).

Verification
REQ-030 ADD rd=3 rs1=1 rs2=2 -> imem_we one cycle later, imem_addr 0, imem_wdata 0x002081B3, count 1.
REQ-031 SUB same fields then ADDI rd=5 rs1=0 imm=10 -> words 0x402081B3 at addr 0, 0x00A00293 at addr 1.
REQ-032 LOAD rd=4 mem_addr=0x3FF -> 0x01FF8203; JAL rd=1 imm=0 -> 0x000000EF.
REQ-033 op_sel 7 -> 0x00000013 written, err=1 held after subsequent valid ops; clear -> err=0, count=0.
REQ-034 ADDR_W=2, stream 5 ADDs -> writes at 0..3, full=1, count=4, 5th never accepted (in_ready 0).
REQ-035 clear (or rst) in cycle of WRITE -> no imem_we pulse, next accepted descriptor writes address 0.
